// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks IF/ID/EX/MEM/WB per opcode class, halts on undefined opcodes.
// Control outputs are combinational from the stage; IF and MEM hold while mem_ready is low (STALL_EN=1).
module stage_sequencer #(
  parameter bit STALL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  OP,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic [2:0]  next_state,
  output logic        IRwrite,
  output logic        PCwrite,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } stage_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BR, C_JMP, C_STK, C_POP, C_ILL
  } op_class_e;

  stage_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  op_class_e   op_class;
  logic        mem_ok;
  logic        last_cycle;

  assign mem_ok = mem_ready | ~STALL_EN;

  always_comb begin
    op_class = C_ILL;
    case (OP)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100:             op_class = C_ALU;
      6'b000101, 6'b000110:             op_class = C_LOAD;
      6'b000111:                        op_class = C_STORE;
      6'b001000, 6'b001001,
      6'b001010, 6'b001011:             op_class = C_BR;
      6'b001100:                        op_class = C_JMP;
      6'b001101, 6'b001110, 6'b001111:  op_class = C_STK;
      6'b010000:                        op_class = C_POP;
      default:                          op_class = C_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  state_d = mem_ok ? S_ID : S_IF;
      S_ID: begin
        case (op_class)
          C_ALU, C_LOAD, C_STORE, C_BR: state_d = S_EX;
          C_JMP:                        state_d = S_IF;
          C_STK, C_POP:                 state_d = S_MEM;
          default:                      state_d = S_HALT;
        endcase
      end
      S_EX: begin
        case (op_class)
          C_ALU:           state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (!mem_ok)                                     state_d = S_MEM;
        else if (op_class == C_LOAD || op_class == C_POP) state_d = S_WB;
        else                                             state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    // Reset overrides everything so the control unit sees IF as the upcoming stage.
    if (!rst_n) state_d = S_IF;
  end

  assign last_cycle = rst_n && (state_q != S_IF) && (state_q != S_HALT) && (state_d == S_IF);

  assign IRwrite    = rst_n && (state_q == S_IF) && (state_d == S_ID);
  assign PCwrite    = last_cycle;
  assign instr_done = last_cycle;

  assign illegal_d = illegal_q | ((state_q == S_ID) && (state_d == S_HALT));
  assign retired_d = retired_q + 16'(instr_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign state      = state_q;
  assign next_state = state_d;
  assign illegal_op = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: inputs change on negedge, outputs sampled 1 time unit later.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  OP;
  logic        mem_ready;
  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        IRwrite;
  logic        PCwrite;
  logic        instr_done;
  logic        illegal_op;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] IF_ = 3'b000, ID_ = 3'b001, EX_ = 3'b010,
                         MEM_ = 3'b011, WB_ = 3'b100, HALT_ = 3'b101;

  stage_sequencer #(.STALL_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .state      (state),
    .next_state (next_state),
    .IRwrite    (IRwrite),
    .PCwrite    (PCwrite),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle's stage and retire strobes, then advances one cycle.
  task automatic expect_stage(input string tag, input logic [2:0] st, input logic last);
    #1;
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".pcwrite"}, 32'(PCwrite), 32'(last));
    check_eq({tag, ".done"}, 32'(instr_done), 32'(last));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    OP        = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst.state", 32'(state), 32'(IF_));
    check_eq("rst.next", 32'(next_state), 32'(IF_));
    check_eq("rst.strobes", 32'({IRwrite, PCwrite, instr_done}), 32'd0);
    check_eq("rst.illegal", 32'(illegal_op), 32'd0);
    check_eq("rst.retired", 32'(retired), 32'd0);

    // SUB interrupted by reset in EX: nothing retires.
    @(negedge clk);
    rst_n = 1'b1;
    OP    = 6'b000010;
    expect_stage("sub.if", IF_, 1'b0);
    expect_stage("sub.id", ID_, 1'b0);
    #1;
    check_eq("sub.ex", 32'(state), 32'(EX_));
    rst_n = 1'b0;
    #1;
    check_eq("sub.rst.pcwrite", 32'(PCwrite), 32'd0);
    check_eq("sub.rst.next", 32'(next_state), 32'(IF_));
    @(negedge clk);
    #1;
    check_eq("sub.rst.state", 32'(state), 32'(IF_));
    check_eq("sub.rst.retired", 32'(retired), 32'd0);
    rst_n = 1'b1;

    // ADD: IF ID EX WB IF.
    OP = 6'b000001;
    #1;
    check_eq("add.irwrite", 32'(IRwrite), 32'd1);
    check_eq("add.next", 32'(next_state), 32'(ID_));
    expect_stage("add.if", IF_, 1'b0);
    check_eq("add.id.irwrite", 32'(IRwrite), 32'd0);
    expect_stage("add.id", ID_, 1'b0);
    expect_stage("add.ex", EX_, 1'b0);
    expect_stage("add.wb", WB_, 1'b1);
    #1;
    check_eq("add.end.state", 32'(state), 32'(IF_));
    check_eq("add.retired", 32'(retired), 32'd1);

    // LW with MEM stalled two cycles: 7 cycles total.
    OP = 6'b000101;
    expect_stage("lw.if", IF_, 1'b0);
    expect_stage("lw.id", ID_, 1'b0);
    expect_stage("lw.ex", EX_, 1'b0);
    mem_ready = 1'b0;
    #1;
    check_eq("lw.stall.next", 32'(next_state), 32'(MEM_));
    expect_stage("lw.mem0", MEM_, 1'b0);
    expect_stage("lw.mem1", MEM_, 1'b0);
    mem_ready = 1'b1;
    expect_stage("lw.mem2", MEM_, 1'b0);
    expect_stage("lw.wb", WB_, 1'b1);
    #1;
    check_eq("lw.end.state", 32'(state), 32'(IF_));
    check_eq("lw.retired", 32'(retired), 32'd2);

    // J with a stalled fetch and a junk opcode during IF.
    OP        = 6'b111111;
    mem_ready = 1'b0;
    #1;
    check_eq("j.ifstall.irwrite", 32'(IRwrite), 32'd0);
    check_eq("j.ifstall.next", 32'(next_state), 32'(IF_));
    expect_stage("j.if0", IF_, 1'b0);
    mem_ready = 1'b1;
    #1;
    check_eq("j.if1.irwrite", 32'(IRwrite), 32'd1);
    expect_stage("j.if1", IF_, 1'b0);
    OP = 6'b001100;
    expect_stage("j.id", ID_, 1'b1);
    #1;
    check_eq("j.end.state", 32'(state), 32'(IF_));
    check_eq("j.retired", 32'(retired), 32'd3);

    // RET: IF ID MEM IF.
    OP = 6'b001110;
    expect_stage("ret.if", IF_, 1'b0);
    expect_stage("ret.id", ID_, 1'b0);
    expect_stage("ret.mem", MEM_, 1'b1);
    #1;
    check_eq("ret.end.state", 32'(state), 32'(IF_));
    check_eq("ret.retired", 32'(retired), 32'd4);

    // Undefined opcode: HALT until reset.
    OP = 6'b010101;
    expect_stage("ill.if", IF_, 1'b0);
    #1;
    check_eq("ill.id.next", 32'(next_state), 32'(HALT_));
    check_eq("ill.id.flag", 32'(illegal_op), 32'd0);
    check_eq("ill.id.pcwrite", 32'(PCwrite), 32'd0);
    @(negedge clk);
    #1;
    check_eq("ill.flag", 32'(illegal_op), 32'd1);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      #1;
      check_eq("ill.halt.state", 32'(state), 32'(HALT_));
      check_eq("ill.halt.next", 32'(next_state), 32'(HALT_));
      check_eq("ill.halt.strobes", 32'({IRwrite, PCwrite, instr_done}), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check_eq("ill.retired", 32'(retired), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_eq("ill.rst.state", 32'(state), 32'(IF_));
    check_eq("ill.rst.flag", 32'(illegal_op), 32'd0);
    check_eq("ill.rst.retired", 32'(retired), 32'd0);
    rst_n = 1'b1;

    // Retire counter wrap: preload near the top, then two ADDs.
    OP = 6'b000000;
    force dut.retired_q = 16'hFFFE;
    @(negedge clk);
    release dut.retired_q;
    #1;
    check_eq("wrap.preload", 32'(retired), 32'h0000FFFE);
    expect_stage("wrap.a.id", ID_, 1'b0);
    expect_stage("wrap.a.ex", EX_, 1'b0);
    expect_stage("wrap.a.wb", WB_, 1'b1);
    #1;
    check_eq("wrap.ffff", 32'(retired), 32'h0000FFFF);
    expect_stage("wrap.b.if", IF_, 1'b0);
    expect_stage("wrap.b.id", ID_, 1'b0);
    expect_stage("wrap.b.ex", EX_, 1'b0);
    expect_stage("wrap.b.wb", WB_, 1'b1);
    #1;
    check_eq("wrap.zero", 32'(retired), 32'h00000000);
    check_eq("wrap.state", 32'(state), 32'(IF_));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
